// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_NBITS = 8;
    localparam int DMEM_DEPTH = 32;
    localparam int DMEM_WAIT  = 2;

    // Width of the wait counter; covers WAIT values 0..15.
    localparam int DMEM_CTR_W = 4;

    // Value loaded into the wait counter on acceptance (WAIT-1, or 0 when no wait).
    function automatic logic [DMEM_CTR_W-1:0] wait_load_value(input int wait_cycles);
        if (wait_cycles > 0) begin
            return DMEM_CTR_W'(wait_cycles - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/dmem_wait_ctr.sv
// Down-counter that times the BUSY phase: load on acceptance, decrement while
// busy, and flag zero so the FSM knows when to move to the response.
module dmem_wait_ctr
    import dmem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  dec,
    input  logic [DMEM_CTR_W-1:0] load_value,
    output logic                  zero
);

    logic [DMEM_CTR_W-1:0] count_reg;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency request/response handshake.
// A request is accepted in IDLE, waits WAIT cycles in BUSY, and completes with
// a one-cycle Done pulse in RESP. Build option: DMEM_RANGE_CHECK_EN enables
// out-of-range detection (Err); without it the address wraps modulo DEPTH.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int NBITS = DMEM_NBITS,
    parameter int DEPTH = DMEM_DEPTH,
    parameter int WAIT  = DMEM_WAIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Valid,
    input  logic             Write,
    input  logic [NBITS-1:2] Address,
    input  logic [NBITS-1:0] WriteData,
    output logic             Ready,
    output logic [NBITS-1:0] ReadData,
    output logic             Done,
    output logic             Err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit HAS_WAIT = (WAIT > 0);
    localparam logic [DMEM_CTR_W-1:0] WAIT_LOAD = wait_load_value(WAIT);

    dmem_state_t state_reg;
    dmem_state_t state_next;

    logic             req_write_reg;
    logic [NBITS-1:2] req_addr_reg;
    logic [NBITS-1:0] req_data_reg;

    logic             accept;
    logic             enter_resp;
    logic             ctr_load;
    logic             ctr_dec;
    logic             ctr_zero;

    logic             eff_write;
    logic [NBITS-1:2] eff_addr;
    logic [NBITS-1:0] eff_data;
    logic [IW-1:0]    word_idx;
    logic             in_range;
    logic             mem_we;

    logic [DEPTH-1:0][NBITS-1:0] words;
    logic [NBITS-1:0]            rdata_reg;

    logic unused_addr_bits;

    dmem_wait_ctr u_wait_ctr (
        .clock      (clock),
        .reset      (reset),
        .load       (ctr_load),
        .dec        (ctr_dec),
        .load_value (WAIT_LOAD),
        .zero       (ctr_zero)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_next = state_reg;
        Ready      = 1'b0;
        Done       = 1'b0;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                Ready = 1'b1;
                if (Valid) begin
                    if (HAS_WAIT) begin
                        state_next = BUSY;
                        ctr_load   = 1'b1;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            BUSY: begin
                ctr_dec = 1'b1;
                if (ctr_zero) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept     = (state_reg == IDLE) && Valid;
    assign enter_resp = (state_next == RESP);

    // Capture the request on acceptance so later input changes are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_write_reg <= 1'b0;
            req_addr_reg  <= '0;
            req_data_reg  <= '0;
        end else if (accept) begin
            req_write_reg <= Write;
            req_addr_reg  <= Address;
            req_data_reg  <= WriteData;
        end
    end

    // With WAIT=0 the response edge is the acceptance edge itself, so the
    // live inputs are used in IDLE and the captured copy otherwise.
    assign eff_write = (state_reg == IDLE) ? Write     : req_write_reg;
    assign eff_addr  = (state_reg == IDLE) ? Address   : req_addr_reg;
    assign eff_data  = (state_reg == IDLE) ? WriteData : req_data_reg;
    assign word_idx  = eff_addr[IW+1:2];

    // Upper address bits only matter when range checking is built in.
    assign unused_addr_bits = ^eff_addr;

`ifdef DMEM_RANGE_CHECK_EN
    logic err_reg;

    assign in_range = (int'(eff_addr) < DEPTH);

    // Err is refreshed on every response and cleared afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= enter_resp && !in_range;
        end
    end

    assign Err = err_reg;
`else
    assign in_range = 1'b1;
    assign Err      = 1'b0;
`endif

    assign mem_we = enter_resp && eff_write && in_range;

    // One register per word so reset can clear the whole array at once.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [NBITS-1:0] word_reg;

        // Word storage: cleared by reset, written on the response edge.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                word_reg <= '0;
            end else if (mem_we && (word_idx == IW'(gi))) begin
                word_reg <= eff_data;
            end
        end

        assign words[gi] = word_reg;
    end

    // Load result: updated only by load responses, zero when out of range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (enter_resp && !eff_write) begin
            rdata_reg <= in_range ? words[word_idx] : '0;
        end
    end

    assign ReadData = rdata_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: one WAIT=2 instance for the main scenarios
// and one WAIT=0 instance for back-to-back handshakes.
module tb_data_mem_responder;

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       valid = 1'b0;
    logic       write = 1'b0;
    logic [7:2] address = '0;
    logic [7:0] wdata = '0;
    logic       ready;
    logic [7:0] rdata;
    logic       done;
    logic       err;

    logic       valid_w0 = 1'b0;
    logic       write_w0 = 1'b0;
    logic [7:2] address_w0 = '0;
    logic [7:0] wdata_w0 = '0;
    logic       ready_w0;
    logic [7:0] rdata_w0;
    logic       done_w0;
    logic       err_w0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.NBITS(8), .DEPTH(32), .WAIT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .Valid     (valid),
        .Write     (write),
        .Address   (address),
        .WriteData (wdata),
        .Ready     (ready),
        .ReadData  (rdata),
        .Done      (done),
        .Err       (err)
    );

    data_mem_responder #(.NBITS(8), .DEPTH(32), .WAIT(0)) dut_w0 (
        .clock     (clock),
        .reset     (reset),
        .Valid     (valid_w0),
        .Write     (write_w0),
        .Address   (address_w0),
        .WriteData (wdata_w0),
        .Ready     (ready_w0),
        .ReadData  (rdata_w0),
        .Done      (done_w0),
        .Err       (err_w0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request on the WAIT=2 instance. After acceptance the inputs are
    // scrambled and Valid stays high until Done, so the captured request and
    // the busy-time Valid rejection are both exercised.
    task automatic req(input bit w, input logic [5:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output logic e);
        int guard;
        @(negedge clock);
        valid = 1'b1; write = w; address = a; wdata = d;
        guard = 0;
        while (!ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock); #1;
        chk("ready_busy", ready, 1'b0);
        write = ~w; address = ~a; wdata = ~d;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        valid = 1'b0;
        rd = rdata;
        e = err;
        $display("req w=%0d a=%0d d=%02h lat=%0d rd=%02h err=%0d", w, a, d, lat, rd, e);
        @(posedge clock); #1;
        chk("done_pulse", done, 1'b0);
        chk("ready_after", ready, 1'b1);
    endtask

    // Back-to-back table for the WAIT=0 instance: inputs before edge i and
    // the expected Done/Ready/ReadData just after it.
    logic       t_w  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] t_d  [8] = '{8'h96, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] t_rd [8] = '{8'h00, 8'h00, 8'h96, 8'h96, 8'h96, 8'h96, 8'h00, 8'h00};

    initial begin
        int lat;
        int seen;
        logic [7:0] rd;
        logic e;

        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Load of a reset-cleared word.
        req(1'b0, 6'd5, 8'h00, lat, rd, e);
        chk("load5_lat", lat, 3);
        chk("load5_rd", rd, 8'h00);
        chk("load5_err", e, 1'b0);

        // Store then load the same word; store leaves ReadData alone.
        req(1'b1, 6'd7, 8'hA5, lat, rd, e);
        chk("store7_lat", lat, 3);
        chk("store7_rd", rd, 8'h00);
        req(1'b0, 6'd7, 8'h00, lat, rd, e);
        chk("load7_rd", rd, 8'hA5);

        req(1'b1, 6'd6, 8'h5A, lat, rd, e);
        chk("store6_rd", rd, 8'hA5);
        req(1'b0, 6'd7, 8'h00, lat, rd, e);
        chk("load7b_rd", rd, 8'hA5);
        req(1'b0, 6'd6, 8'h00, lat, rd, e);
        chk("load6_rd", rd, 8'h5A);

        // Word 40 is beyond DEPTH=32: aliases word 8 or reports Err.
        req(1'b1, 6'd40, 8'h11, lat, rd, e);
        chk("store40_err", e, RC);
        chk("store40_rd", rd, 8'h5A);
        req(1'b0, 6'd8, 8'h00, lat, rd, e);
        chk("load8_rd", rd, RC ? 8'h00 : 8'h11);
        chk("load8_err", e, 1'b0);
        req(1'b0, 6'd6, 8'h00, lat, rd, e);
        chk("load6b_rd", rd, 8'h5A);
        req(1'b0, 6'd40, 8'h00, lat, rd, e);
        chk("load40_rd", rd, RC ? 8'h00 : 8'h11);
        chk("load40_err", e, RC);

        // Reset in the first BUSY cycle aborts the store.
        req(1'b1, 6'd2, 8'h3C, lat, rd, e);
        chk("store2_lat", lat, 3);
        @(negedge clock);
        valid = 1'b1; write = 1'b1; address = 6'd2; wdata = 8'hFF;
        @(posedge clock); #1;
        valid = 1'b0;
        chk("abort_busy", ready, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_ready", ready, 1'b1);
        chk("abort_rdata", rdata, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        $display("abort store word 2: done pulses=%0d", seen);
        chk("abort_no_done", seen, 0);
        req(1'b0, 6'd2, 8'h00, lat, rd, e);
        chk("load2_rd", rd, 8'h00);

        // Reset on the acceptance edge drops the request.
        req(1'b1, 6'd3, 8'h42, lat, rd, e);
        @(negedge clock);
        valid = 1'b1; write = 1'b0; address = 6'd3; reset = 1'b1;
        @(posedge clock); #1;
        valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        $display("reset on acceptance: done pulses=%0d", seen);
        chk("rstacc_no_done", seen, 0);
        chk("rstacc_rdata", rdata, 8'h00);

        // WAIT=0, Valid held high: Done right after each acceptance,
        // acceptances two cycles apart.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            valid_w0 = 1'b1; write_w0 = t_w[i]; address_w0 = 6'd9; wdata_w0 = t_d[i];
            @(posedge clock); #1;
            $display("w0 edge %0d w=%0d d=%02h done=%0d ready=%0d rd=%02h",
                     i, t_w[i], t_d[i], done_w0, ready_w0, rdata_w0);
            chk("w0_done", done_w0, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("w0_ready", ready_w0, (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("w0_rdata", rdata_w0, t_rd[i]);
        end
        valid_w0 = 1'b0;
        chk("w0_err", err_w0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter NBITS, default 8: data word width and byte-address width.
REQ-002 Parameter DEPTH, default 32: number of words stored; SHALL be a power of 2 and at most 2^(NBITS-2).
REQ-003 Parameter WAIT, default 2: wait cycles between acceptance and response; range 0..15.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 Valid  input  1  initiator request valid; held high until accepted.
REQ-007 Write  input  1  1 = store, 0 = load.
REQ-008 Address  input  NBITS-2, indexed [NBITS-1:2]  word address.
REQ-009 WriteData  input  NBITS  store data.
REQ-010 Ready  output  1  responder can accept a request this cycle.
REQ-011 ReadData  output  NBITS  registered load result.
REQ-012 Done  output  1  one-cycle response pulse.
REQ-013 Err  output  1  out-of-range flag, qualified by Done.

Function
REQ-014 FSM states SHALL be IDLE, BUSY and RESP; Ready=1 only in IDLE; Done=1 only in RESP.
REQ-015 Acceptance SHALL occur on an edge where Valid=1 and the FSM is in IDLE; Write, Address and WriteData SHALL be latched on that edge, and later input changes SHALL be ignored.
REQ-016 On acceptance, the FSM SHALL go to BUSY with counter=WAIT-1 if WAIT>0, else directly to RESP.
REQ-017 In BUSY, the counter SHALL decrement each cycle; when it is 0, the next state SHALL be RESP.
REQ-018 Latency: Done SHALL be high exactly WAIT+1 cycles after the acceptance edge.
REQ-019 Stores SHALL commit to the array, and load data SHALL load into ReadData, on the edge entering RESP.
REQ-020 RESP SHALL always return to IDLE the next cycle, so the minimum request spacing is WAIT+2 cycles.
REQ-021 ReadData SHALL hold its value until the next load response; stores SHALL leave ReadData unchanged.
REQ-022 A load following a store to the same word SHALL return the stored value.
REQ-023 Valid asserted while not in IDLE SHALL have no effect.

Reset
REQ-024 Reset SHALL force IDLE, counter=0, ReadData=0, Done=0, Err=0 and Ready=1 (in IDLE), and SHALL clear all DEPTH words to 0.
REQ-025 Reset asserted in BUSY SHALL abort the transaction: no store commits and no Done is produced.
REQ-026 Reset asserted on the same edge as acceptance SHALL take priority, so the request is dropped.

Configuration
REQ-027 Macro DMEM_RANGE_CHECK_EN.
- Defined: Address >= DEPTH yields Done with Err=1; the store is suppressed and ReadData is loaded with 0.
- Undefined: Address is reduced modulo DEPTH (low bits only), and Err is constant 0.

Structure
REQ-028 Package dmem_pkg SHALL hold:
- enum typedef dmem_state_t {IDLE, BUSY, RESP};
- the default constants DMEM_NBITS=8, DMEM_DEPTH=32, DMEM_WAIT=2.
REQ-029 The wait counter SHALL be the sub-module dmem_wait_ctr, with load, decrement and a zero flag, 4 bits wide.

Verification
REQ-030 Reset followed by a load at Address=5 -> Done in cycle 3 after acceptance, ReadData=0x00, Err=0.
REQ-031 Store 0xA5 at word 7, then load word 7 -> second Done shows ReadData=0xA5; ReadData is unchanged after the store Done.
REQ-032 WAIT=0, back-to-back requests with Valid held high -> Done one cycle after each acceptance, and acceptances spaced 2 cycles apart.
REQ-033 Store 0x3C at word 2, then reset in the first BUSY cycle of a store of 0xFF to word 2, then load word 2 -> no Done for the aborted store, and the load returns 0x00 (reset cleared the array).
REQ-034 With DMEM_RANGE_CHECK_EN: store 0x11 to word 40 (DEPTH=32) -> Done with Err=1; a load of word 8 returns its prior value, not 0x11.
REQ-035 Without DMEM_RANGE_CHECK_EN: store 0x11 to word 40 then load word 8 -> ReadData=0x11 and Err=0.
